// File: rtl/mux4to1_scan_pkg.sv
// mux4to1_scan_pkg
//   Shared types and constants for the 4:1 mux scan controller.
//   - state_e : scan FSM states (2-bit encoding)
//   - N_CH    : number of mux channels scanned
//   - SEL_W   : width of the channel select
package mux4to1_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mux4to1_case.sv
// mux4to1_case
//   Case-statement 4:1 multiplexer; the downstream mux driven by the scan
//   controller.
//   Ports:
//     d_i   [3:0] data inputs, d_i[i] selected when sel_i == i
//     sel_i [1:0] channel select
//     y_o         selected data bit
module mux4to1_case (
  input  logic [3:0] d_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);

  always_comb begin
    y_o = 1'b0;
    case (sel_i)
      2'd0:    y_o = d_i[0];
      2'd1:    y_o = d_i[1];
      2'd2:    y_o = d_i[2];
      default: y_o = d_i[3];
    endcase
  end

endmodule

// File: rtl/mux4to1_scan_dwell.sv
// mux4to1_scan_dwell
//   Settle timer for one channel of the scan. Counts up while enabled and
//   flags the last settle cycle.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     clr      force the count back to zero on the next edge
//     en       advance the count by one
//     expired  count has reached DWELL-1 (last settle cycle)
module mux4to1_scan_dwell #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Reject out-of-range configurations at elaboration time.
  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("mux4to1_scan_dwell: DWELL must be in 1..255");
  end
  if ((DWELL - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("mux4to1_scan_dwell: CNT_W too narrow for DWELL");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mux4to1_scan.sv
// mux4to1_scan
//   Scan controller for the 4:1 mux family. Steps sel through channels 0..3,
//   lets each channel settle for DWELL cycles, samples mux_out for one cycle,
//   then publishes the 4-bit snapshot on result with a one-cycle done pulse.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset (overrides everything)
//     start    begin a scan (only honoured in IDLE)
//     stop     abort to IDLE from any state, no done pulse
//     cont     1 = rescan after DONE, 0 = return to IDLE (sampled in DONE)
//     mux_out  output of the downstream mux
//     sel      channel select driven to the mux
//     result   snapshot; result[i] = mux_out seen while sel == i
//     busy     high whenever the FSM is not in IDLE
//     done     one-cycle pulse when result has been refreshed
module mux4to1_scan
  import mux4to1_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  result,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [N_CH-2:0]   shadow_q;   // samples of channels 0..N_CH-2
  logic [N_CH-1:0]   result_q;
  logic              busy_q;
  logic              done_q;

  logic dwell_clr;
  logic dwell_en;
  logic dwell_expired;

  // The counter only runs inside SETTLE; it is zeroed on the expiry edge and
  // everywhere else, so every entry into SETTLE starts from zero.
  assign dwell_en  = (state_q == SETTLE);
  assign dwell_clr = stop || (state_q != SETTLE) || dwell_expired;

  mux4to1_scan_dwell #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clr     (dwell_clr),
    .en      (dwell_en),
    .expired (dwell_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (stop) begin
      // Abort: partial samples are dropped, the last good result survives.
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q <= '0;
          if (start) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (dwell_expired) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (sel_q != LAST_CH) begin
            shadow_q[sel_q] <= mux_out;
            sel_q           <= sel_q + 1'b1;
            state_q         <= SETTLE;
          end else begin
            // Last channel goes straight into result alongside the shadow.
            result_q <= {mux_out, shadow_q};
            state_q  <= DONE;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          sel_q <= '0;
          if (cont) begin
            state_q <= SETTLE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mux4to1_scan.sv
module tb_mux4to1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DWELL=2
  logic       rst_a = 1'b0, start_a = 1'b0, stop_a = 1'b0, cont_a = 1'b0;
  logic [3:0] din_a = 4'b0000;
  logic       mux_a;
  logic [1:0] sel_a;
  logic [3:0] result_a;
  logic       busy_a, done_a;

  // Instance B: DWELL=1
  logic       rst_b = 1'b0, start_b = 1'b0, stop_b = 1'b0, cont_b = 1'b0;
  logic [3:0] din_b = 4'b0000;
  logic       mux_b;
  logic [1:0] sel_b;
  logic [3:0] result_b;
  logic       busy_b, done_b;

  mux4to1_case u_mux_a (.d_i(din_a), .sel_i(sel_a), .y_o(mux_a));
  mux4to1_scan #(.DWELL(2), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a), .cont(cont_a),
    .mux_out(mux_a), .sel(sel_a), .result(result_a), .busy(busy_a), .done(done_a)
  );

  mux4to1_case u_mux_b (.d_i(din_b), .sel_i(sel_b), .y_o(mux_b));
  mux4to1_scan #(.DWELL(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .cont(cont_b),
    .mux_out(mux_b), .sel(sel_b), .result(result_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] din;
    logic [3:0] exp_result;
    bit         poke_start;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done on A is seen; n = edges taken, or -1 on timeout.
  task automatic wait_done_a(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done_a && n < 100);
    if (!done_a) n = -1;
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done_b && n < 100);
    if (!done_b) n = -1;
  endtask

  // Single-shot scan on A with sel/busy tracking; returns edges to done.
  task automatic scan_a(input logic [3:0] din, input bit poke_start, output int n);
    din_a   = din;
    start_a = 1'b1;
    step();             // edge 0 samples start
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 60) begin
      if (n < 12) begin
        check("sel_seq", 32'(sel_a), 32'(n / 3));
        check("busy_scan", 32'(busy_a), 32'd1);
      end
      start_a = poke_start && (n == 4 || n == 8);
      step();
      n++;
    end
    start_a = 1'b0;
    if (!done_a) n = -1;
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int dones;

    vecs[0] = '{din: 4'b1010, exp_result: 4'b1010, poke_start: 1'b0};
    vecs[1] = '{din: 4'b0101, exp_result: 4'b0101, poke_start: 1'b0};
    vecs[2] = '{din: 4'b1111, exp_result: 4'b1111, poke_start: 1'b1};
    vecs[3] = '{din: 4'b0000, exp_result: 4'b0000, poke_start: 1'b0};
    vecs[4] = '{din: 4'b1000, exp_result: 4'b1000, poke_start: 1'b1};
    vecs[5] = '{din: 4'b0001, exp_result: 4'b0001, poke_start: 1'b0};

    // Reset state
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_result_a", 32'(result_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_result_b", 32'(result_b), 32'd0);
    $display("reset: sel=%0d result=%b busy=%b done=%b", sel_a, result_a, busy_a, done_a);

    // start and stop together in IDLE: stop wins
    start_a = 1'b1; stop_a = 1'b1;
    step();
    start_a = 1'b0; stop_a = 1'b0;
    check("collide_busy", 32'(busy_a), 32'd0);
    step();
    check("collide_busy2", 32'(busy_a), 32'd0);
    $display("collision: busy=%b", busy_a);

    // Single-shot table
    cont_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      scan_a(vecs[i].din, vecs[i].poke_start, n);
      check("done_edge", 32'(n), 32'd12);
      check("result", 32'(result_a), 32'(vecs[i].exp_result));
      $display("scan din=%b poke=%0d edges=%0d result=%b", vecs[i].din, vecs[i].poke_start, n, result_a);
      step();
      check("done_pulse", 32'(done_a), 32'd0);
      check("busy_after", 32'(busy_a), 32'd0);
      check("sel_after", 32'(sel_a), 32'd0);
      check("result_hold", 32'(result_a), 32'(vecs[i].exp_result));
      step();
    end

    // Continuous scanning
    cont_a = 1'b1;
    scan_a(4'b0110, 1'b0, n);
    check("cont_first_edge", 32'(n), 32'd12);
    check("cont_first_result", 32'(result_a), 32'h6);
    $display("cont scan1 edges=%0d result=%b", n, result_a);
    din_a = 4'b1001;
    wait_done_a(n);
    check("cont_period", 32'(n), 32'd13);
    check("cont_second_result", 32'(result_a), 32'h9);
    $display("cont scan2 period=%0d result=%b", n, result_a);
    din_a = 4'b0110;
    wait_done_a(n);
    check("cont_period3", 32'(n), 32'd13);
    check("cont_third_result", 32'(result_a), 32'h6);
    $display("cont scan3 period=%0d result=%b", n, result_a);

    // Abort during ch2 SAMPLE of the fourth scan
    n = 0;
    while (sel_a != 2'd2 && n < 50) begin
      step();
      n++;
    end
    check("reach_ch2", 32'(sel_a), 32'd2);
    step(); step();     // now in SAMPLE of ch2
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
    cont_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_sel", 32'(sel_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_result", 32'(result_a), 32'h6);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done_a || busy_a) dones++;
    end
    check("abort_quiet", 32'(dones), 32'd0);
    $display("abort: busy=%b sel=%0d result=%b", busy_a, sel_a, result_a);

    // Instance B (DWELL=1): normal scan, reset mid-scan, normal scan
    din_b = 4'b1101;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done_b(n);
    check("b_done_edge", 32'(n), 32'd8);
    check("b_result", 32'(result_b), 32'hD);
    $display("b scan din=%b edges=%0d result=%b", din_b, n, result_b);
    step();

    start_b = 1'b1;
    step();             // edge 0
    start_b = 1'b0;
    step();             // edge 1: SAMPLE ch0
    step();             // edge 2: SETTLE ch1
    check("b_mid_sel", 32'(sel_b), 32'd1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("b_rst_sel", 32'(sel_b), 32'd0);
    check("b_rst_result", 32'(result_b), 32'd0);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_done", 32'(done_b), 32'd0);
    $display("b reset mid-scan: sel=%0d result=%b busy=%b", sel_b, result_b, busy_b);

    din_b = 4'b0011;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done_b(n);
    check("b_done_edge2", 32'(n), 32'd8);
    check("b_result2", 32'(result_b), 32'h3);
    $display("b scan din=%b edges=%0d result=%b", din_b, n, result_b);
    step();
    check("b_busy_after", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4to1_scan.md
Name: mux4to1_scan

Overview:
- Upstream control stage for the 4:1 mux family (mux4to1_inst / mux4to1_if / mux4to1_case).
- Drives the mux `sel` through channels 0..3, waits a programmable settle time on each channel, then samples the mux output.
- Assembles the four samples into a 4-bit snapshot and pulses `done` when the snapshot is ready.
- Supports single-shot and continuous scanning.

Parameters:
- DWELL, 4, settle cycles per channel before sampling; legal range 1..255; values outside this range are a configuration error.
- CNT_W, 8, width of the dwell counter; requires DWELL-1 < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort; valid in any state.
- cont  input  1  1 = continuous scanning, 0 = single-shot; sampled in DONE.
- mux_out  input  1  output of the downstream 4:1 mux.
- sel  output  2  channel select driven to the mux.
- result  output  4  snapshot; result[i] = mux_out sampled while sel==i.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result is valid and new.

Behaviour:
- Clock and reset: one clock domain, `clk`. Reset `rst` is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset values: state=IDLE, sel=0, cnt=0, shadow=0, result=0, busy=0, done=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel held at 0.
  - start=1 and stop=0 -> SETTLE, sel=0, cnt=0.
  - Otherwise remain in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==DWELL-1 -> SAMPLE.
  - SETTLE therefore lasts exactly DWELL cycles. sel is stable throughout.
- SAMPLE (one cycle):
  - On the exit edge, shadow[sel] <= mux_out.
  - If sel<3: sel <= sel+1, cnt <= 0, -> SETTLE.
  - If sel==3: result <= {mux_out, shadow[2:0]}, -> DONE.
- DONE (one cycle):
  - done=1 (registered state decode, no combinational path from inputs).
  - cont=1 -> SETTLE with sel=0, cnt=0.
  - cont=0 -> IDLE, sel=0.
- Latency: done rises 4*(DWELL+1) edges after the edge that sampled start, and falls on the following edge.
  - Continuous-mode period: 4*(DWELL+1)+1 cycles between done pulses.
- Width rules:
  - sel increments 0->1->2->3 only; it never wraps through increment. Return to 0 happens only via the DONE or IDLE transitions.
  - cnt resets to 0 on every channel change.
- stop:
  - stop=1 in any state -> IDLE on the next edge, sel=0, cnt=0, no done pulse.
  - result keeps its previous value; shadow contents are discarded.
- Simultaneous events:
  - start=1 together with stop=1 in IDLE: stop wins, remain in IDLE.
  - start while busy: ignored.
  - stop during DONE: done still shows for that cycle; the next state is IDLE regardless of cont.
- Reset mid-scan: rst overrides everything, including stop and start. All registers return to their reset values on that edge.
- result changes only on the SAMPLE(ch3)->DONE edge and on reset.

Decomposition:
- Package mux4to1_scan_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE} (2-bit encoding);
  - localparams N_CH=4 and SEL_W=2.
- Sub-module mux4to1_scan_dwell: CNT_W-bit dwell timer.
  - Inputs: clr, en.
  - Output: expired = (cnt==DWELL-1).
- The FSM, sel register and shadow/result registers stay in the top module.

Test Plan:
- Bench wiring: the bench instantiates mux4to1_case with sel driven by the DUT and mux_out taken from the mux; DWELL=2 unless noted.
- Single-shot: {in3,in2,in1,in0}=4'b1010, start one cycle, cont=0 -> done high exactly 12 edges after start, result=4'b1010, busy falls with done, sel=0 afterwards.
- Sel sequence: same run -> sel is 0,0,0,1,1,1,2,2,2,3,3,3 across cycles 1..12 (DWELL+1=3 cycles per channel).
- Continuous: cont=1, inputs 4'b0110; change inputs to 4'b1001 during the second scan before ch0 is sampled -> first done result=4'b0110, second done result=4'b1001, done pulses 13 cycles apart.
- Abort: stop=1 during the SAMPLE cycle of ch2 with a prior result of 4'b0110 -> IDLE next edge, busy=0, sel=0, no done, result remains 4'b0110.
- Start/stop collision and busy start:
  - start=stop=1 in IDLE -> busy stays 0.
  - start pulses while busy -> scan length is unchanged (done at edge 12).
- Reset mid-scan: rst=1 during SETTLE of ch1 -> next edge sel=0, result=0, busy=0, done=0. A following start completes normally with DWELL=1 and done at edge 8.
